// File: rtl/ifu.sv
// Instruction fetch unit: issues one fetch at the current PC, holds the
// returned instruction until the execute stage accepts it, then loads the
// next PC. A misaligned next PC parks the unit in a sticky error state that
// only reset clears.
//
// Handshake rules:
//   imem side  : imem_req_o is high for the whole FETCH state and the fetch
//                completes on the first cycle with imem_ack_i=1 (this may be
//                the same cycle the request first appears). Acks arriving in
//                any other state are ignored.
//   decode side: inst_valid_o stays high with inst_o/pc_o stable until
//                inst_valid_o && inst_ready_i. new_pc_i is sampled only then.
//                inst_ready_i has no effect while inst_valid_o is low.
module ifu #(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [INST_WIDTH-1:0] imem_rdata_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] new_pc_i,
    output logic                  fetch_error_o,
    output logic [DATA_WIDTH-1:0] inst_count_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [INST_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] r_count;
    logic                  w_handshake;

    assign w_handshake = (r_state == ST_VALID) && inst_ready_i;

    // FSM plus PC, instruction latch and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack_i) begin
                        r_inst  <= imem_rdata_i;
                        r_state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (w_handshake) begin
                        r_pc    <= new_pc_i;
                        r_count <= r_count + 1'b1;
                        r_state <= (new_pc_i[1:0] == 2'b00) ? ST_FETCH : ST_ERR;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_ERR;
                end
            endcase
        end
    end

    // Outputs decode from registered state only; nothing reaches them
    // combinationally from inst_ready_i or new_pc_i.
    assign imem_req_o    = (r_state == ST_FETCH);
    assign inst_valid_o  = (r_state == ST_VALID);
    assign fetch_error_o = (r_state == ST_ERR);
    assign imem_addr_o   = r_pc;
    assign pc_o          = r_pc;
    assign inst_o        = r_inst;
    assign inst_count_o  = r_count;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: a directed sequence on a 64-bit instance plus a counter
// wrap run on an 8-bit instance. Every fetched instruction is pushed into
// an expected queue as {inst, pc}; a monitor pops and compares each time
// the DUT raises inst_valid_o.
module tb_ifu;

    localparam int DW = 64;
    localparam int IW = 32;
    localparam int SW = IW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ack;
    logic [IW-1:0] rdata;
    logic          ready;
    logic [DW-1:0] new_pc;
    logic          req;
    logic [DW-1:0] addr;
    logic          valid;
    logic [IW-1:0] inst;
    logic [DW-1:0] pc;
    logic          err;
    logic [DW-1:0] count;
    logic [1:0]    dbg_state;

    ifu #(.DATA_WIDTH(DW), .RESET_PC(64'h0), .INST_WIDTH(IW)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .inst_valid_o  (valid),
        .inst_ready_i  (ready),
        .inst_o        (inst),
        .pc_o          (pc),
        .new_pc_i      (new_pc),
        .fetch_error_o (err),
        .inst_count_o  (count),
        .dbg_state_o   (dbg_state)
    );

    // Reduced-width instance used for the counter wrap run.
    logic          rst2;
    logic          req2;
    logic [7:0]    addr2;
    logic          valid2;
    logic [IW-1:0] inst2;
    logic [7:0]    pc2;
    logic          err2;
    logic [7:0]    count2;
    logic [1:0]    dbg_state2;

    ifu #(.DATA_WIDTH(8), .RESET_PC(8'h0), .INST_WIDTH(IW)) dut8 (
        .clk           (clk),
        .rst           (rst2),
        .imem_req_o    (req2),
        .imem_addr_o   (addr2),
        .imem_ack_i    (1'b1),
        .imem_rdata_i  (32'h0000_0013),
        .inst_valid_o  (valid2),
        .inst_ready_i  (1'b1),
        .inst_o        (inst2),
        .pc_o          (pc2),
        .new_pc_i      (8'h00),
        .fetch_error_o (err2),
        .inst_count_o  (count2),
        .dbg_state_o   (dbg_state2)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [SW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each rising inst_valid_o presents one instruction.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        logic [SW-1:0] e;
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got inst %0h pc %0h, queue empty", inst, pc);
            end else begin
                e = exp_q.pop_front();
                check("mon_inst", DW'(inst), DW'(e[SW-1:DW]));
                check("mon_pc", pc, e[DW-1:0]);
            end
        end
        prev_valid <= valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_inst(input logic [IW-1:0] i_word, input logic [DW-1:0] i_pc);
        exp_q.push_back({i_word, i_pc});
    endtask

    // Watchdog: the sequence is fixed length, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; ack = 1'b0; rdata = '0; ready = 1'b0; new_pc = '0;
        rst2 = 1'b1;
        tick(2);

        // Reset state
        check("rst_pc", pc, 64'h0);
        check("rst_count", count, 64'h0);
        check("rst_inst", DW'(inst), 64'h0);
        check("rst_valid", DW'(valid), 64'h0);
        check("rst_err", DW'(err), 64'h0);

        // First request right after release, zero-wait ack
        rst = 1'b0;
        check("first_req", DW'(req), 64'h1);
        check("first_addr", addr, 64'h0);
        ack = 1'b1; rdata = 32'h0050_0093;
        expect_inst(32'h0050_0093, 64'h0);
        tick();
        ack = 1'b0;
        check("zw_valid", DW'(valid), 64'h1);
        check("zw_inst", DW'(inst), 64'h0050_0093);
        check("zw_pc", pc, 64'h0);
        check("zw_req", DW'(req), 64'h0);

        // Accept, next PC 0x4
        ready = 1'b1; new_pc = 64'h4;
        tick();
        ready = 1'b0;
        check("hs1_pc", pc, 64'h4);
        check("hs1_count", count, 64'h1);
        check("hs1_req", DW'(req), 64'h1);
        check("hs1_valid", DW'(valid), 64'h0);

        // Ack delayed 3 cycles: request held with address 4
        for (int i = 0; i < 3; i++) begin
            check("wait_req", DW'(req), 64'h1);
            check("wait_addr", addr, 64'h4);
            check("wait_valid", DW'(valid), 64'h0);
            tick();
        end
        check("wait_req4", DW'(req), 64'h1);
        ack = 1'b1; rdata = 32'h0010_0113;
        expect_inst(32'h0010_0113, 64'h4);
        tick();
        check("dly_valid", DW'(valid), 64'h1);
        // Further acks while VALID must be ignored
        rdata = 32'hDEAD_BEEF;
        tick(2);
        ack = 1'b0;
        check("ign_ack_inst", DW'(inst), 64'h0010_0113);

        // Stall 5 cycles with new_pc toggling (must not matter)
        for (int i = 0; i < 5; i++) begin
            new_pc = 64'h100 + 64'(i);
            tick();
            check("stall_inst", DW'(inst), 64'h0010_0113);
            check("stall_pc", pc, 64'h4);
            check("stall_valid", DW'(valid), 64'h1);
        end
        ready = 1'b1; new_pc = 64'h10;
        tick();
        check("hs2_pc", pc, 64'h10);
        check("hs2_count", count, 64'h2);
        check("hs2_req", DW'(req), 64'h1);
        // Ready while fetching has no effect
        new_pc = 64'h99;
        tick(2);
        ready = 1'b0;
        check("rdy_fetch_pc", pc, 64'h10);
        check("rdy_fetch_count", count, 64'h2);

        // Fetch at 0x10, jump to 0x40, then reset during the 0x40 wait
        ack = 1'b1; rdata = 32'h0000_0073;
        expect_inst(32'h0000_0073, 64'h10);
        tick();
        ack = 1'b0;
        ready = 1'b1; new_pc = 64'h40;
        tick();
        ready = 1'b0;
        check("j40_pc", pc, 64'h40);
        check("j40_count", count, 64'h3);
        tick(2);
        check("j40_wait_addr", addr, 64'h40);
        rst = 1'b1; ack = 1'b1;
        tick();
        rst = 1'b0; ack = 1'b0;
        check("midrst_pc", pc, 64'h0);
        check("midrst_count", count, 64'h0);
        check("midrst_inst", DW'(inst), 64'h0);
        check("midrst_valid", DW'(valid), 64'h0);
        check("midrst_req", DW'(req), 64'h1);
        check("midrst_addr", addr, 64'h0);

        // Misaligned target -> sticky error
        ack = 1'b1; rdata = 32'h0220_0067;
        expect_inst(32'h0220_0067, 64'h0);
        tick();
        ack = 1'b0;
        ready = 1'b1; new_pc = 64'h22;
        tick();
        check("err_pc", pc, 64'h22);
        check("err_flag", DW'(err), 64'h1);
        check("err_count", count, 64'h1);
        ack = 1'b1; new_pc = 64'h8;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_hold_flag", DW'(err), 64'h1);
            check("err_hold_req", DW'(req), 64'h0);
            check("err_hold_valid", DW'(valid), 64'h0);
            check("err_hold_pc", pc, 64'h22);
        end
        ack = 1'b0; ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("err_rst_pc", pc, 64'h0);
        check("err_rst_flag", DW'(err), 64'h0);
        check("err_rst_req", DW'(req), 64'h1);

        // Counter wrap on the 8-bit instance: one handshake every 2 cycles
        rst2 = 1'b0;
        tick(510);
        check("wrap_255", DW'(count2), 64'hFF);
        tick(2);
        check("wrap_0", DW'(count2), 64'h0);

        tick(2);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
